// File: rtl/elevator_display_pkg.sv
// Shared codes, direction encodings and phase type for the elevator cabin display path.
// Imported by the sequencer, the display decoder and the floor-control blocks.
package elevator_display_pkg;

  localparam logic [3:0] CODE_WAIT      = 4'd0;
  localparam logic [3:0] CODE_UP        = 4'd5;
  localparam logic [3:0] CODE_OPEN      = 4'd6;
  localparam logic [3:0] CODE_CLOSED    = 4'd7;
  localparam logic [3:0] CODE_DOWN      = 4'd8;
  localparam logic [3:0] CODE_FLOOR_IND = 4'd9;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'b00,
    PH_ANNOUNCE = 2'b01,
    PH_FLOOR    = 2'b10,
    PH_STATUS   = 2'b11
  } phase_t;

  function automatic logic floor_valid(input logic [2:0] f);
    return (f >= 3'd1) && (f <= 3'd4);
  endfunction

  // An open door outranks direction; the unused direction 11 reads as stopped.
  function automatic logic [3:0] status_code(input logic [1:0] d, input logic door);
    if (door) return CODE_OPEN;
    case (d)
      DIR_UP:   return CODE_UP;
      DIR_DOWN: return CODE_DOWN;
      default:  return CODE_CLOSED;
    endcase
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Phase hold timer: counts 0..HOLD_CYCLES-1 and pulses expire on the last count.
// restart clears the count on the next edge; no backpressure.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || expire) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/elevator_display_sequencer.sv
// Sequences cabin display codes: announce, floor, then floor/status alternating, each held HOLD_CYCLES.
// Outputs registered, one cycle from upd; no backpressure, the last upd wins.
module elevator_display_sequencer
  import elevator_display_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [2:0] floor,
  input  logic [1:0] dir,
  input  logic       door_open,
  output logic [3:0] BCD,
  output logic [1:0] phase
);

  phase_t     state;
  logic [2:0] lat_floor;
  logic [1:0] lat_dir;
  logic       lat_open;
  logic       expire;
  logic       restart;
  logic       upd_invalid;
  logic       upd_new_floor;
  logic [1:0] eff_dir;
  logic       eff_open;
  logic [3:0] eff_status;

  assign upd_invalid   = upd && !floor_valid(floor);
  assign upd_new_floor = upd && floor_valid(floor) &&
                         ((state == PH_IDLE) || (floor != lat_floor));

  // A same-floor update takes effect in the same cycle, so status follows it immediately.
  assign eff_dir    = upd ? dir       : lat_dir;
  assign eff_open   = upd ? door_open : lat_open;
  assign eff_status = status_code(eff_dir, eff_open);

  // The timer is parked at zero in IDLE and cleared whenever the sequence is restarted.
  assign restart = (state == PH_IDLE) || upd_invalid || upd_new_floor;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .expire  (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PH_IDLE;
      BCD       <= CODE_WAIT;
      lat_floor <= '0;
      lat_dir   <= '0;
      lat_open  <= 1'b0;
    end else if (upd_invalid) begin
      state     <= PH_IDLE;
      BCD       <= CODE_WAIT;
      lat_floor <= '0;
      lat_dir   <= '0;
      lat_open  <= 1'b0;
    end else if (upd_new_floor) begin
      state     <= PH_ANNOUNCE;
      BCD       <= CODE_FLOOR_IND;
      lat_floor <= floor;
      lat_dir   <= dir;
      lat_open  <= door_open;
    end else begin
      if (upd) begin
        lat_dir  <= dir;
        lat_open <= door_open;
      end
      case (state)
        PH_ANNOUNCE: begin
          if (expire) begin
            state <= PH_FLOOR;
            BCD   <= {1'b0, lat_floor};
          end
        end
        PH_FLOOR: begin
          if (expire) begin
            state <= PH_STATUS;
            BCD   <= eff_status;
          end
        end
        PH_STATUS: begin
          if (expire) begin
            state <= PH_FLOOR;
            BCD   <= {1'b0, lat_floor};
          end else begin
            BCD   <= eff_status;
          end
        end
        default: begin
          state <= PH_IDLE;
          BCD   <= CODE_WAIT;
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_elevator_display_sequencer.sv
// Scoreboard bench: a time-since-announce model predicts each cycle's BCD/phase; a monitor compares.
module tb_elevator_display_sequencer;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd;
  logic [2:0] floor;
  logic [1:0] dir;
  logic       door_open;
  logic [3:0] BCD;
  logic [1:0] phase;

  always #5 clk = ~clk;

  elevator_display_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd       (upd),
    .floor     (floor),
    .dir       (dir),
    .door_open (door_open),
    .BCD       (BCD),
    .phase     (phase)
  );

  typedef struct packed {
    logic [3:0] bcd;
    logic [1:0] ph;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: t is cycles elapsed since the announce began; phase follows from t by division.
  bit m_active = 0;
  int m_t      = 0;
  int m_floor  = 0;
  int m_dir    = 0;
  int m_door   = 0;

  function automatic int status_of(input int d, input int o);
    if (o != 0) return 6;
    if (d == 1) return 5;
    if (d == 2) return 8;
    return 7;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    if (!m_active)          begin e.bcd = 4'd0; e.ph = 2'd0; end
    else if (m_t < H)       begin e.bcd = 4'd9; e.ph = 2'd1; end
    else if (((m_t - H) / H) % 2 == 0) begin e.bcd = 4'(m_floor); e.ph = 2'd2; end
    else begin e.bcd = 4'(status_of(m_dir, m_door)); e.ph = 2'd3; end
    return e;
  endfunction

  task automatic step(input bit r, input bit u, input int f, input int d, input bit o);
    rst = r; upd = u; floor = 3'(f); dir = 2'(d); door_open = o;
    if (r) begin
      m_active = 0; m_t = 0; m_floor = 0; m_dir = 0; m_door = 0;
    end else if (u && (f < 1 || f > 4)) begin
      m_active = 0; m_t = 0; m_floor = 0; m_dir = 0; m_door = 0;
    end else if (u && (!m_active || f != m_floor)) begin
      m_active = 1; m_t = 0; m_floor = f; m_dir = d; m_door = int'(o);
    end else begin
      if (u) begin m_dir = d; m_door = int'(o); end
      if (m_active) m_t++;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, m_floor, m_dir, m_door[0]);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (BCD !== e.bcd || phase !== e.ph) begin
        failures++;
        $display("FAIL cycle_out t=%0t: BCD=%0d phase=%0d, required BCD=%0d phase=%0d",
                 $time, BCD, phase, e.bcd, e.ph);
      end
    end
  end

  initial begin
    rst = 1'b1; upd = 1'b0; floor = '0; dir = '0; door_open = 1'b0;
    @(negedge clk);

    // Reset with upd asserted: upd must be ignored
    step(1, 1, 3, 1, 0);
    step(1, 1, 3, 1, 0);
    idle(3);

    // Basic sequence: floor 3 going up
    step(0, 1, 3, 1, 0);
    idle(17);
    // Status refresh in second STATUS cycle: door opens
    step(0, 1, 3, 1, 1);
    idle(3);
    // Floor change mid-FLOOR
    step(0, 1, 2, 2, 0);
    idle(9);
    step(0, 1, 2, 3, 0);
    idle(6);

    // Invalid floors in STATUS
    step(0, 1, 0, 1, 0);
    idle(6);
    step(0, 1, 1, 1, 0);
    idle(9);
    step(0, 1, 5, 0, 0);
    idle(6);

    // New floor on the ANNOUNCE expiry cycle
    step(0, 1, 1, 0, 0);
    idle(3);
    step(0, 1, 4, 1, 1);
    idle(10);

    // Same-floor update on a FLOOR expiry cycle, then reset mid-sequence
    step(0, 1, 3, 2, 0);
    idle(7);
    step(0, 1, 3, 1, 0);
    idle(2);
    step(1, 1, 2, 1, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      int  f, d;
      bit  r, u, o;
      r = ($urandom_range(0, 199) == 0);
      u = ($urandom_range(0, 5) == 0);
      if (m_active && $urandom_range(0, 1) == 1) f = m_floor;
      else f = $urandom_range(0, 7);
      d = $urandom_range(0, 3);
      o = 1'($urandom_range(0, 1));
      if (u) step(r, 1, f, d, o);
      else   step(r, 0, f, d, o);
    end
    idle(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
